imem_loader: RTL

Boot-time writer for the core's instruction memory. Receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and drives a word-addressed write port into instruction memory. It holds the pipelined core in reset until a complete image with a correct checksum has been written. It sits beside the top level and feeds the instruction memory's write side, the opposite end from the core's fetch port.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_if.sv | 31 +++
 rtl/loader_word_assembler.sv | 47 ++++
 rtl/imem_loader.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the instruction-memory boot loader.
//   state_e        : loader FSM states
//   BYTES_PER_WORD : stream bytes per instruction word
//   CSUM_W         : width of the running XOR checksum
//   CNT_W          : width of the word-count field at the head of the stream
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        CNT0,
        CNT1,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int CSUM_W         = 8;
    localparam int CNT_W          = 16;

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Byte-stream handshake plus instruction-memory write port of the loader.
//   byte_valid / byte_data / byte_ready : incoming boot byte stream
//   imem_we / imem_addr / imem_wdata    : word-addressed write port
// Modports:
//   master : the side feeding bytes and observing the memory write port
//   slave  : the loader itself
// -----------------------------------------------------------------------------
interface imem_loader_if #(
    parameter int ADDR_W = 8
) ();

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/loader_word_assembler.sv
// -----------------------------------------------------------------------------
// loader_word_assembler
// Packs accepted stream bytes, LSB first, into 32-bit little-endian words.
//   clk          : core clock
//   clear_i      : restart at lane 0 (reset or reload)
//   strobe_i     : a payload byte is accepted this cycle
//   byte_i       : the accepted byte
//   word_valid_o : the 4th byte of a word is being accepted this cycle
//   word_o       : the completed word, valid while word_valid_o is high
// word_valid_o/word_o are combinational so the parent can register the write
// port in the cycle right after the final byte is accepted.
// -----------------------------------------------------------------------------
module loader_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        clear_i,
    input  logic        strobe_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    localparam int LANE_W  = $clog2(BYTES_PER_WORD);
    localparam int SHIFT_W = 8 * (BYTES_PER_WORD - 1);

    logic [LANE_W-1:0]  lane_q;
    logic [SHIFT_W-1:0] shift_q;

    // Only the lane counter is cleared.
    // NOTE: the shift register needs no reset: word_valid_o is gated by the
    // lane counter, and every stale bit is overwritten before it can be used.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            lane_q <= '0;
        end else if (strobe_i) begin
            // NOTE: non-blocking assignments here, so every register sees the
            // pre-edge value of the others regardless of statement order.
            lane_q  <= lane_q + 1'b1;
            shift_q <= {byte_i, shift_q[SHIFT_W-1:8]};
        end
    end

    assign word_valid_o = strobe_i && !clear_i && (lane_q == LANE_W'(BYTES_PER_WORD - 1));
    assign word_o       = {byte_i, shift_q};

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot-time writer for the instruction memory. Parses the stream
//   count_lo, count_hi, 4*N payload bytes (LSB first), XOR checksum byte
// writes each assembled word to imem and keeps the core in reset until a full
// image with a matching checksum has been loaded.
//   clk          : core clock
//   rst          : synchronous active-low reset
//   bus          : byte stream handshake + imem write port (slave modport)
//   reload       : one-cycle pulse, restarts loading from DONE or ERR
//   core_hold    : high except in DONE
//   done         : image loaded and checksum matched
//   error        : word count above L_imem, or checksum mismatch
//   words_loaded : words written since the last start
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter  int L_imem = 256,
    localparam int ADDR_W = $clog2(L_imem)
) (
    input  logic              clk,
    input  logic              rst,
    imem_loader_if.slave      bus,
    input  logic              reload,
    output logic              core_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    state_e              state_q, state_d;
    logic [7:0]          count_lo_q;
    logic [CNT_W-1:0]    count_q;
    logic [CSUM_W-1:0]   csum_q;
    logic [ADDR_W:0]     words_loaded_q;
    logic                byte_ready_q;
    logic                imem_we_q;
    logic [ADDR_W-1:0]   imem_addr_q;
    logic [31:0]         imem_wdata_q;
    logic                core_hold_q;
    logic                done_q;
    logic                error_q;

    logic                accept;
    logic                reload_ok;
    logic [CNT_W-1:0]    count_full;
    logic [ADDR_W:0]     words_next;
    logic                word_valid;
    logic [31:0]         word;
    logic                last_word;
    logic                asm_clear;

    assign accept     = bus.byte_valid && byte_ready_q;
    assign reload_ok  = reload && (state_q == DONE || state_q == ERR);
    assign count_full = {bus.byte_data, count_lo_q};
    assign words_next = words_loaded_q + 1'b1;
    // words_loaded < N while in DATA, so words_next never exceeds L_imem.
    assign last_word  = word_valid && (CNT_W'(words_next) == count_q);
    assign asm_clear  = !rst || reload_ok;

    loader_word_assembler u_word_asm (
        .clk          (clk),
        .clear_i      (asm_clear),
        .strobe_i     (accept && state_q == DATA),
        .byte_i       (bus.byte_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        // NOTE: default first, so no path through the case leaves state_d
        // unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            CNT0: if (accept) state_d = CNT1;
            CNT1: begin
                if (accept) begin
                    if (32'(count_full) > 32'(L_imem)) state_d = ERR;
                    else if (count_full == '0)         state_d = CSUM;
                    else                               state_d = DATA;
                end
            end
            DATA: if (last_word) state_d = CSUM;
            CSUM: begin
                if (accept) state_d = (bus.byte_data == csum_q) ? DONE : ERR;
            end
            DONE, ERR: if (reload) state_d = CNT0;
            default: state_d = CNT0;
        endcase
    end

    // Status outputs are registered from the next state so they change in the
    // same cycle the FSM enters the new state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= CNT0;
            count_lo_q     <= '0;
            count_q        <= '0;
            csum_q         <= '0;
            words_loaded_q <= '0;
            byte_ready_q   <= 1'b0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            core_hold_q    <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_ready_q <= state_d inside {CNT0, CNT1, DATA, CSUM};
            core_hold_q  <= (state_d != DONE);
            done_q       <= (state_d == DONE);
            error_q      <= (state_d == ERR);
            imem_we_q    <= word_valid;

            if (word_valid) begin
                imem_addr_q    <= words_loaded_q[ADDR_W-1:0];
                imem_wdata_q   <= word;
                words_loaded_q <= words_next;
            end

            // The checksum byte itself is compared, not accumulated.
            if (accept && state_q != CSUM) csum_q <= csum_q ^ bus.byte_data;
            if (accept && state_q == CNT0) count_lo_q <= bus.byte_data;
            if (accept && state_q == CNT1) count_q <= count_full;

            if (reload_ok) begin
                words_loaded_q <= '0;
                csum_q         <= '0;
            end
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign core_hold      = core_hold_q;
    assign done           = done_q;
    assign error          = error_q;
    assign words_loaded   = words_loaded_q;

endmodule
